// File: rtl/mdu_ctrl_if.sv
// Command/result bundle between the E stage and the multiply/divide sequencer.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, a, b, md_use,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, md_use,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; the result is computed at issue
// and held in shadow registers until the fixed latency expires.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    mdu_ctrl_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_res_hi, r_res_lo, r_hi, r_lo;
    logic          r_res_wr, r_busy;

    logic [63:0] w_a_sx, w_b_sx, w_mul_s, w_mul_u;
    logic [31:0] w_abs_a, w_abs_b, w_div_s_b, w_div_u_b;
    logic [31:0] w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;
    logic [31:0] w_res_hi, w_res_lo;
    logic        w_arith, w_is_div, w_b_zero;

    assign w_a_sx  = {{32{bus.a[31]}}, bus.a};
    assign w_b_sx  = {{32{bus.b[31]}}, bus.b};
    assign w_mul_s = w_a_sx * w_b_sx;
    assign w_mul_u = {32'd0, bus.a} * {32'd0, bus.b};

    // Signed divide via magnitudes; this also yields 0x80000000 / -1 = 0x80000000, rem 0.
    assign w_abs_a   = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    assign w_abs_b   = bus.b[31] ? (32'd0 - bus.b) : bus.b;
    assign w_b_zero  = (bus.b == 32'd0);
    assign w_div_s_b = w_b_zero ? 32'd1 : w_abs_b;
    assign w_div_u_b = w_b_zero ? 32'd1 : bus.b;
    assign w_q_mag   = w_abs_a / w_div_s_b;
    assign w_r_mag   = w_abs_a % w_div_s_b;
    assign w_q_s     = (bus.a[31] ^ bus.b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s     = bus.a[31] ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_q_u     = bus.a / w_div_u_b;
    assign w_r_u     = bus.a % w_div_u_b;

    // Select the 64-bit result and classify the incoming command.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_arith  = 1'b0;
        w_is_div = 1'b0;
        case (bus.md_op)
            OP_MULT:  begin {w_res_hi, w_res_lo} = w_mul_s; w_arith = 1'b1; end
            OP_MULTU: begin {w_res_hi, w_res_lo} = w_mul_u; w_arith = 1'b1; end
            OP_DIV:   begin w_res_hi = w_r_s; w_res_lo = w_q_s; w_arith = 1'b1; w_is_div = 1'b1; end
            OP_DIVU:  begin w_res_hi = w_r_u; w_res_lo = w_q_u; w_arith = 1'b1; w_is_div = 1'b1; end
            default:  begin w_res_hi = 32'd0; w_res_lo = 32'd0; end
        endcase
    end

    // Sequencer: issue in IDLE, count down in RUN, commit HI/LO together on the last cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_arith) begin
                        r_res_hi <= w_res_hi;
                        r_res_lo <= w_res_lo;
                        r_res_wr <= !(w_is_div && w_b_zero);
                        r_count  <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else if (bus.start && bus.md_op == OP_MTHI) begin
                        r_hi <= bus.a;
                    end else if (bus.start && bus.md_op == OP_MTLO) begin
                        r_lo <= bus.a;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Commands arriving here, including on the final cycle, are dropped.
                    if (r_count == CW'(1)) begin
                        if (r_res_wr) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.stall = bus.md_use & (r_busy | (bus.start & w_arith));

endmodule
